// File: rtl/axi4_lite_master_pkg.sv
// Shared types for the AXI4-Lite master:
// FSM encodings and AXI response codes.
package axi4_lite_master_pkg;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'd0;
  localparam resp_t RESP_SLVERR = 2'd2;
  localparam resp_t RESP_DECERR = 2'd3;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  localparam logic [3:0] STRB_ALL     = 4'hF;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns AMCI strobes into
// full write/read transactions on two independent FSMs.
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,

  input  logic [AW-1:0] AMCI_WADDR,
  input  logic [31:0]   AMCI_WDATA,
  input  logic          AMCI_WRITE,
  output logic [1:0]    AMCI_WRESP,
  output logic          AMCI_WIDLE,

  input  logic [AW-1:0] AMCI_RADDR,
  input  logic          AMCI_READ,
  output logic [31:0]   AMCI_RDATA,
  output logic [1:0]    AMCI_RRESP,
  output logic          AMCI_RIDLE,

  output logic [AW-1:0] M_AXI_AWADDR,
  output logic          M_AXI_AWVALID,
  output logic [2:0]    M_AXI_AWPROT,
  input  logic          M_AXI_AWREADY,

  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,

  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,

  output logic [AW-1:0] M_AXI_ARADDR,
  output logic          M_AXI_ARVALID,
  output logic [2:0]    M_AXI_ARPROT,
  input  logic          M_AXI_ARREADY,

  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  w_state_t w_state;
  r_state_t r_state;

  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;
  logic ar_hs;

  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;
  assign M_AXI_WSTRB  = STRB_ALL;

  // Handshake and "channel finished" terms for the write FSM
  assign aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID & M_AXI_WREADY;
  assign aw_done = ~M_AXI_AWVALID | aw_hs;
  assign w_done  = ~M_AXI_WVALID | w_hs;
  assign ar_hs   = M_AXI_ARVALID & M_AXI_ARREADY;

  // Idle flags drop in the same cycle as the strobe
  assign AMCI_WIDLE = ~AMCI_WRITE & (w_state == W_IDLE);
  assign AMCI_RIDLE = ~AMCI_READ & (r_state == R_IDLE);

  // Write FSM: AW and W may complete in any order
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state       <= W_IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      AMCI_WRESP    <= RESP_OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (AMCI_WRITE) begin
            M_AXI_AWADDR  <= AMCI_WADDR;
            M_AXI_WDATA   <= AMCI_WDATA;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            w_state       <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (aw_hs)
            M_AXI_AWVALID <= 1'b0;
          if (w_hs)
            M_AXI_WVALID <= 1'b0;
          if (aw_done && w_done) begin
            M_AXI_BREADY <= 1'b1;
            w_state      <= W_RESP;
          end
        end
        W_RESP: begin
          if (M_AXI_BVALID) begin
            AMCI_WRESP   <= M_AXI_BRESP;
            M_AXI_BREADY <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: begin
          M_AXI_AWVALID <= 1'b0;
          M_AXI_WVALID  <= 1'b0;
          M_AXI_BREADY  <= 1'b0;
          w_state       <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: address phase then data phase
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= R_IDLE;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      AMCI_RDATA    <= '0;
      AMCI_RRESP    <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (AMCI_READ) begin
            M_AXI_ARADDR  <= AMCI_RADDR;
            M_AXI_ARVALID <= 1'b1;
            r_state       <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_AXI_RVALID) begin
            AMCI_RDATA   <= M_AXI_RDATA;
            AMCI_RRESP   <= M_AXI_RRESP;
            M_AXI_RREADY <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b0;
          r_state       <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with
// a small reactive AXI4-Lite slave model.
module tb_axi4_lite_master;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;

  logic [AW-1:0] amci_waddr = '0;
  logic [31:0]   amci_wdata = '0;
  logic          amci_write = 1'b0;
  logic [1:0]    amci_wresp;
  logic          amci_widle;
  logic [AW-1:0] amci_raddr = '0;
  logic          amci_read = 1'b0;
  logic [31:0]   amci_rdata;
  logic [1:0]    amci_rresp;
  logic          amci_ridle;

  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic [2:0]    awprot;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic [2:0]    arprot;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  // slave configuration, driven by the stimulus
  logic          awready_cfg = 1'b1;
  logic          wready_cfg = 1'b1;
  logic          arready_cfg = 1'b1;
  logic [1:0]    bresp_cfg = 2'd0;
  logic [31:0]   rdata_cfg = '0;
  logic [1:0]    rresp_cfg = 2'd0;

  logic          aw_got;
  logic          w_got;
  logic          ar_got;
  int            aw_hs_cnt;
  logic [AW-1:0] aw_seen;
  logic [31:0]   w_seen;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign awready = awready_cfg;
  assign wready  = wready_cfg;
  assign arready = arready_cfg;

  axi4_lite_master #(.AW(AW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .AMCI_WADDR    (amci_waddr),
    .AMCI_WDATA    (amci_wdata),
    .AMCI_WRITE    (amci_write),
    .AMCI_WRESP    (amci_wresp),
    .AMCI_WIDLE    (amci_widle),
    .AMCI_RADDR    (amci_raddr),
    .AMCI_READ     (amci_read),
    .AMCI_RDATA    (amci_rdata),
    .AMCI_RRESP    (amci_rresp),
    .AMCI_RIDLE    (amci_ridle),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARPROT  (arprot),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  // Slave: response is registered one cycle after
  // both request handshakes have been recorded.
  always @(posedge clk) begin
    if (!resetn) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      ar_got    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= 2'd0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rresp     <= 2'd0;
      aw_hs_cnt <= 0;
      aw_seen   <= '0;
      w_seen    <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_got    <= 1'b1;
        aw_seen   <= awaddr;
        aw_hs_cnt <= aw_hs_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got  <= 1'b1;
        w_seen <= wdata;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= bresp_cfg;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (arvalid && arready)
        ar_got <= 1'b1;
      if (ar_got && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= rdata_cfg;
        rresp  <= rresp_cfg;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        ar_got <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_widle(input string tag);
    int n = 0;
    while (!amci_widle && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, amci_widle}, 32'd1);
  endtask

  task automatic wait_ridle(input string tag);
    int n = 0;
    while (!amci_ridle && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, amci_ridle}, 32'd1);
  endtask

  initial begin
    // reset
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_rdata", amci_rdata, 32'd0);
    chk("rst_resp", {28'd0, amci_wresp, amci_rresp}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("rst_idle", {30'd0, amci_widle, amci_ridle}, 32'd3);
    chk("const_prot", {26'd0, awprot, arprot}, 32'd0);
    chk("const_strb", {28'd0, wstrb}, 32'hF);

    // zero-wait write 0x1000 -> 0x04
    amci_waddr = 32'h04;
    amci_wdata = 32'h1000;
    amci_write = 1'b1;
    #1;
    chk("w0_idle_strobe", {31'd0, amci_widle}, 32'd0);
    tick();
    amci_write = 1'b0;
    amci_waddr = 32'h55;
    chk("w0_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    chk("w0_c1_awaddr", awaddr, 32'h04);
    chk("w0_c1_wdata", wdata, 32'h1000);
    chk("w0_c1_bready", {31'd0, bready}, 32'd0);
    tick();
    chk("w0_c2_bready", {31'd0, bready}, 32'd1);
    chk("w0_c2_valids", {30'd0, awvalid, wvalid}, 32'd0);
    tick();
    chk("w0_c3_idle", {31'd0, amci_widle}, 32'd0);
    tick();
    chk("w0_c4_idle", {31'd0, amci_widle}, 32'd1);
    chk("w0_wresp", {30'd0, amci_wresp}, 32'd0);
    chk("w0_bready_off", {31'd0, bready}, 32'd0);
    chk("w0_slave_data", w_seen, 32'h1000);

    // AWREADY held off three cycles, WREADY immediate
    awready_cfg = 1'b0;
    bresp_cfg = 2'd2;
    amci_waddr = 32'h20;
    amci_wdata = 32'hA5A5_0001;
    amci_write = 1'b1;
    tick();
    amci_write = 1'b0;
    chk("w1_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
    tick();
    chk("w1_c2_wvalid", {31'd0, wvalid}, 32'd0);
    chk("w1_c2_awvalid", {31'd0, awvalid}, 32'd1);
    chk("w1_c2_bready", {31'd0, bready}, 32'd0);
    tick();
    chk("w1_c3_awvalid", {31'd0, awvalid}, 32'd1);
    chk("w1_c3_awaddr", awaddr, 32'h20);
    chk("w1_c3_bready", {31'd0, bready}, 32'd0);
    tick();
    chk("w1_c4_awvalid", {31'd0, awvalid}, 32'd1);
    chk("w1_c4_awaddr", awaddr, 32'h20);
    chk("w1_c4_bready", {31'd0, bready}, 32'd0);
    awready_cfg = 1'b1;
    tick();
    chk("w1_c5_awvalid", {31'd0, awvalid}, 32'd0);
    chk("w1_c5_bready", {31'd0, bready}, 32'd1);
    wait_widle("w1_done");
    chk("w1_wresp", {30'd0, amci_wresp}, 32'd2);

    // read 0x04 -> DEADBEEF / DECERR
    rdata_cfg = 32'hDEAD_BEEF;
    rresp_cfg = 2'd3;
    amci_raddr = 32'h04;
    amci_read = 1'b1;
    #1;
    chk("r0_idle_strobe", {31'd0, amci_ridle}, 32'd0);
    tick();
    amci_read = 1'b0;
    chk("r0_c1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("r0_c1_araddr", araddr, 32'h04);
    chk("r0_c1_rready", {31'd0, rready}, 32'd0);
    tick();
    chk("r0_c2_arvalid", {31'd0, arvalid}, 32'd0);
    chk("r0_c2_rready", {31'd0, rready}, 32'd1);
    tick();
    chk("r0_c3_idle", {31'd0, amci_ridle}, 32'd0);
    tick();
    chk("r0_c4_idle", {31'd0, amci_ridle}, 32'd1);
    chk("r0_rdata", amci_rdata, 32'hDEAD_BEEF);
    chk("r0_rresp", {30'd0, amci_rresp}, 32'd3);

    // simultaneous write + read, second write ignored
    bresp_cfg = 2'd0;
    rdata_cfg = 32'h1234_5678;
    rresp_cfg = 2'd0;
    amci_waddr = 32'h30;
    amci_wdata = 32'h0000_0030;
    amci_raddr = 32'h40;
    amci_write = 1'b1;
    amci_read = 1'b1;
    tick();
    amci_read = 1'b0;
    amci_waddr = 32'h99;
    amci_wdata = 32'hFFFF_FFFF;
    chk("c_c1_both", {29'd0, awvalid, wvalid, arvalid}, 32'd7);
    tick();
    amci_write = 1'b0;
    chk("c_c2_awaddr", awaddr, 32'h30);
    wait_widle("c_wdone");
    wait_ridle("c_rdone");
    tick();
    tick();
    chk("c_aw_count", aw_hs_cnt, 32'd3);
    chk("c_aw_addr", aw_seen, 32'h30);
    chk("c_w_data", w_seen, 32'h30);
    chk("c_rdata", amci_rdata, 32'h1234_5678);
    chk("c_rresp", {30'd0, amci_rresp}, 32'd0);
    chk("c_idle", {30'd0, amci_widle, amci_ridle}, 32'd3);

    // reset while in W_RESP
    amci_waddr = 32'h50;
    amci_wdata = 32'h5;
    amci_write = 1'b1;
    tick();
    amci_write = 1'b0;
    tick();
    chk("rw_in_resp", {31'd0, bready}, 32'd1);
    resetn = 1'b0;
    tick();
    chk("rw_signals", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("rw_idle", {30'd0, amci_widle, amci_ridle}, 32'd3);

    // reset while in R_ADDR
    arready_cfg = 1'b0;
    amci_raddr = 32'h60;
    amci_read = 1'b1;
    tick();
    amci_read = 1'b0;
    tick();
    chk("rr_in_addr", {31'd0, arvalid}, 32'd1);
    resetn = 1'b0;
    tick();
    chk("rr_signals", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    arready_cfg = 1'b1;
    resetn = 1'b1;
    tick();
    chk("rr_idle", {30'd0, amci_widle, amci_ridle}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

AXI4-Lite bus master that converts single-cycle user command strobes into complete AXI4-Lite write and read transactions, then returns the response and read data to the user. It is the initiator end of the AXI4-Lite slave cores used by our datapath blocks, for config sequencers and self-test logic that drive a block's control registers. Write and read channels run independent state machines and may be active at the same time.

## Interface
Parameters:
- AW, 32, address width for AMCI addresses and AXI AWADDR/ARADDR.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- AMCI_WADDR  in  AW  write byte address; sampled on the cycle AMCI_WRITE is high.
- AMCI_WDATA  in  32  write data; sampled with AMCI_WADDR.
- AMCI_WRITE  in  1  one-cycle strobe that starts a write.
- AMCI_WRESP  out  2  BRESP of the last completed write.
- AMCI_WIDLE  out  1  write side is idle and can accept AMCI_WRITE.
- AMCI_RADDR  in  AW  read byte address; sampled on the cycle AMCI_READ is high.
- AMCI_READ  in  1  one-cycle strobe that starts a read.
- AMCI_RDATA  out  32  RDATA of the last completed read.
- AMCI_RRESP  out  2  RRESP of the last completed read.
- AMCI_RIDLE  out  1  read side is idle.
- M_AXI_AWADDR/AWVALID/AWPROT  out  AW/1/3  AXI AW channel.
- M_AXI_AWREADY  in  1  AXI AW channel.
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  AXI W channel.
- M_AXI_WREADY  in  1  AXI W channel.
- M_AXI_BRESP/BVALID  in  2/1  AXI B channel.
- M_AXI_BREADY  out  1  AXI B channel.
- M_AXI_ARADDR/ARVALID/ARPROT  out  AW/1/3  AXI AR channel.
- M_AXI_ARREADY  in  1  AXI AR channel.
- M_AXI_RDATA/RRESP/RVALID  in  32/2/1  AXI R channel.
- M_AXI_RREADY  out  1  AXI R channel.

## Operation
- Constant outputs: AWPROT = ARPROT = 0; WSTRB = 4'hF.
- Write FSM states:
  - W_IDLE: on AMCI_WRITE, latch the address into AWADDR and the data into WDATA, set AWVALID = WVALID = 1, go to W_ADDR_DATA.
  - W_ADDR_DATA: drop AWVALID on the AW handshake (AWVALID & AWREADY). Drop WVALID on the W handshake. The two handshakes can occur in either order or in the same cycle. When both are done, set BREADY = 1 and go to W_RESP.
  - W_RESP: on BVALID, latch AMCI_WRESP = BRESP, clear BREADY, go to W_IDLE.
- Read FSM states:
  - R_IDLE: on AMCI_READ, latch ARADDR, set ARVALID, go to R_ADDR.
  - R_ADDR: on the AR handshake, clear ARVALID, set RREADY, go to R_DATA.
  - R_DATA: on RVALID, latch AMCI_RDATA and AMCI_RRESP, clear RREADY, go to R_IDLE.
- AMCI_WIDLE = (AMCI_WRITE == 0) && (write state == W_IDLE). AMCI_RIDLE is defined the same way for the read side. Both are combinational, so idle goes low in the same cycle as the strobe.
- AMCI_WRITE while the write FSM is not idle is ignored: no latch, no state change. The same rule applies to AMCI_READ on the read side.
- A write and a read may start in the same cycle. The two sides never stall each other.
- Once a VALID is asserted, it stays high, and its address/data stay stable, until the matching handshake. There is no timeout.

## Timing
- Reset values: all VALID and READY outputs 0, AWADDR/WDATA/ARADDR 0, AMCI_WRESP/AMCI_RRESP/AMCI_RDATA 0, both FSMs in their idle state.
- AWVALID and WVALID rise 1 cycle after AMCI_WRITE. ARVALID rises 1 cycle after AMCI_READ.
- With a zero-wait slave (READY held high, response returned on the cycle after the handshake), each transaction takes 4 cycles from strobe to the idle flag going high again. AMCI results are valid on the cycle idle returns high.
- BREADY is asserted only in W_RESP. RREADY is asserted only in R_DATA. A BVALID that arrives before both AW and W handshakes is held off by BREADY = 0 and is not accepted.
- Reset mid-transaction takes effect on the next edge: all VALIDs drop and both FSMs return to idle. Bus recovery is the system's responsibility, and the slave is reset together with this block.

## Structure
- A shared package holds the FSM state encodings and the response codes OKAY = 0, SLVERR = 2, DECERR = 3. These codes are also used by the slave side.
- No sub-module. The write and read FSMs are two always blocks in this one module.

## Test plan
- Zero-wait slave; write 0x1000 to address 0x04 -> AWVALID and WVALID high one cycle after the strobe, BREADY high in the next cycle, AMCI_WRESP = 0, AMCI_WIDLE high 4 cycles after the strobe.
- AWREADY delayed 3 cycles, WREADY given immediately -> WVALID drops after 1 cycle, AWVALID stays high with AWADDR stable until AWREADY, BREADY does not rise until both handshakes are done.
- Read of address 0x04 with RDATA = 0xDEADBEEF and RRESP = DECERR -> AMCI_RDATA = 0xDEADBEEF, AMCI_RRESP = 3.
- AMCI_WRITE and AMCI_READ in the same cycle -> both transactions complete independently, and a second AMCI_WRITE issued mid-transaction is ignored (only one AW handshake occurs).
- resetn low while in W_RESP, and separately while in R_ADDR -> every VALID and READY is 0 on the next edge, and both idle flags are high after reset is released.
